memory_reader_32_7: RTL and testbench

Streaming read client for the 32-bit x 128-entry synchronous memory. Accepts a start command (base address, word count), drives the memory read-address port, absorbs the memory's fixed 2-cycle read latency with a 2-stage return pipe and a 4-entry output FIFO, and presents the words as a valid/ready stream with a last marker. It sits between the memory's read port and any downstream consumer (DMA, layer-load sequencer) and keeps sustained 1 word/cycle throughput under backpressure without losing in-flight data.

---
 rtl/memory_reader_32_7_if.sv | 35 +++
 rtl/memory_reader_32_7.sv | 133 +++++++++++++
 tb/tb_memory_reader_32_7.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_reader_32_7_if.sv
// memory_reader_32_7_if: command, memory read port and output stream of the memory reader; abort/aborted exist only with MEMORY_READER_ABORT_EN
interface memory_reader_32_7_if;
    logic        start;
    logic [6:0]  start_address;
    logic [7:0]  start_length;
    logic        busy;
    logic        done;
    logic [6:0]  m_rd_address;
    logic [31:0] m_rd_data;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_data;
    logic        out_last;
`ifdef MEMORY_READER_ABORT_EN
    logic        abort;
    logic        aborted;
    modport master (
        input  start, start_address, start_length, m_rd_data, out_rdy, abort,
        output busy, done, m_rd_address, out_vld, out_data, out_last, aborted
    );
    modport slave (
        output start, start_address, start_length, m_rd_data, out_rdy, abort,
        input  busy, done, m_rd_address, out_vld, out_data, out_last, aborted
    );
`else
    modport master (
        input  start, start_address, start_length, m_rd_data, out_rdy,
        output busy, done, m_rd_address, out_vld, out_data, out_last
    );
    modport slave (
        output start, start_address, start_length, m_rd_data, out_rdy,
        input  busy, done, m_rd_address, out_vld, out_data, out_last
    );
`endif
endinterface

// File: rtl/memory_reader_32_7.sv
// memory_reader_32_7: streams a burst of words from a 2-cycle-latency memory into a 4-deep valid/ready FIFO; optional abort via MEMORY_READER_ABORT_EN
module memory_reader_32_7 (
    input logic                  clk,
    input logic                  reset,
    memory_reader_32_7_if.master bus
);
`ifdef MEMORY_READER_ABORT_EN
    typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, ABORT} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
`endif
    state_t      state, nxt;
    logic [6:0]  addr, rd_addr_q;
    logic [7:0]  remaining, len;
    logic        p0_v, p0_l, p1_v, p1_l;
    logic [31:0] fifo_data [4];
    logic        fifo_last [4];
    logic [1:0]  wr_ptr, rd_ptr, inflight;
    logic [2:0]  fifo_count;
    logic        issue, push, pop, last_hs, abort_now, discard;

    assign len      = bus.start_length > 8'd128 ? 8'd128 : bus.start_length;
    assign inflight = {1'b0, p0_v} + {1'b0, p1_v};
    // Credit check counts words already buffered plus words still in the return pipe
    assign issue    = state == READ && remaining != 8'd0 && !abort_now && (fifo_count + {1'b0, inflight}) < 3'd4;
    assign push     = p1_v && !discard;
    assign pop      = bus.out_vld && bus.out_rdy;
    assign last_hs  = pop && bus.out_last;
`ifdef MEMORY_READER_ABORT_EN
    assign abort_now = bus.abort && (state == READ || state == DRAIN);
    assign discard   = abort_now || state == ABORT;
`else
    assign abort_now = 1'b0;
    assign discard   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = bus.start ? (len == 8'd0 ? DONE : READ) : IDLE;
            READ:  nxt = abort_now ? state_t'(nxt) : (issue && remaining == 8'd1) ? DRAIN : READ;
            DRAIN: nxt = abort_now ? state_t'(nxt) : last_hs ? DONE : DRAIN;
            DONE:  nxt = IDLE;
`ifdef MEMORY_READER_ABORT_EN
            ABORT: nxt = inflight == 2'd0 ? IDLE : ABORT;
`endif
            default: nxt = IDLE;
        endcase
`ifdef MEMORY_READER_ABORT_EN
        if (abort_now) nxt = ABORT;
`endif
    end

    // Status outputs decoded from state; address holds its last issued value when idle
    always_comb begin
        bus.busy         = state != IDLE;
        bus.done         = state == DONE;
        bus.m_rd_address = issue ? addr : rd_addr_q;
`ifdef MEMORY_READER_ABORT_EN
        bus.aborted      = state == ABORT && inflight == 2'd0;
`endif
    end

    // Command latch and address/count advance on each issued read
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= 7'd0;
            remaining <= 8'd0;
            rd_addr_q <= 7'd0;
        end else if (state == IDLE && bus.start) begin
            addr      <= bus.start_address;
            remaining <= len;
        end else if (issue) begin
            addr      <= addr + 7'd1;
            remaining <= remaining - 8'd1;
            rd_addr_q <= addr;
        end
    end

    // Two-stage return pipe tracking reads whose data has not yet arrived
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_v <= 1'b0;
            p0_l <= 1'b0;
            p1_v <= 1'b0;
            p1_l <= 1'b0;
        end else begin
            p0_v <= issue;
            p0_l <= issue && remaining == 8'd1;
            p1_v <= p0_v;
            p1_l <= p0_l;
        end
    end

    // Output FIFO; abort empties it immediately while the pipe drains separately
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= 32'd0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else if (abort_now) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= bus.m_rd_data;
                fifo_last[wr_ptr] <= p1_l;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + {2'd0, push} - {2'd0, pop};
        end
    end

    // Stream outputs come straight from the FIFO head registers
    always_comb begin
        bus.out_vld  = fifo_count != 3'd0;
        bus.out_data = fifo_data[rd_ptr];
        bus.out_last = bus.out_vld && fifo_last[rd_ptr];
    end
endmodule

// File: tb/tb_memory_reader_32_7.sv
// tb_memory_reader_32_7: directed scoreboard bench for memory_reader_32_7 (abort scenario only with MEMORY_READER_ABORT_EN)
module tb_memory_reader_32_7;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    int hs = 0;
    logic [32:0] q[$];
    logic [31:0] mem [128];
    logic [31:0] rd1;

    memory_reader_32_7_if bus();
    memory_reader_32_7 dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Memory model: address in cycle t, data visible in cycle t+2
    always @(posedge clk) begin
        rd1 <= mem[bus.m_rd_address];
        bus.m_rd_data <= rd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [6:0] a, input logic [7:0] l, input bit expect_words);
        int n;
        logic [6:0] wa;
        n = l > 8'd128 ? 128 : int'(l);
        bus.start = 1'b1;
        bus.start_address = a;
        bus.start_length = l;
        if (expect_words)
            for (int i = 0; i < n; i++) begin
                wa = a + 7'(i);
                q.push_back({i == n - 1, 32'h100 + {25'd0, wa}});
            end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        tick();
    endtask

    // Scoreboard: every handshake pops the oldest expected word
    always @(negedge clk) begin
        if (!reset && bus.out_vld && bus.out_rdy) begin
            hs++;
            if (q.size() == 0) check("unexpected_word", bus.out_data, 32'hDEAD_BEEF);
            else begin
                logic [32:0] e;
                e = q.pop_front();
                check("data", bus.out_data, e[31:0]);
                check("last", {31'd0, bus.out_last}, {31'd0, e[32]});
            end
        end
    end

    // Credit bound: buffered plus in-flight words never exceed the FIFO depth
    always @(negedge clk) begin
        if (!reset && bus.busy)
            check("credit", {31'd0, (int'(dut.fifo_count) + int'(dut.inflight)) <= 4}, 32'd1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_addr [4];
        int seen_done;
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 32'h100 + i;
        bus.start = 1'b0;
        bus.start_address = 7'd0;
        bus.start_length = 8'd0;
        bus.out_rdy = 1'b0;
`ifdef MEMORY_READER_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_vld", {31'd0, bus.out_vld}, 32'd0);
        check("rst_last", {31'd0, bus.out_last}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_addr", {25'd0, bus.m_rd_address}, 32'd0);

        // Basic burst with exact latency and done timing
        bus.out_rdy = 1'b1;
        cmd(7'd5, 8'd4, 1'b1);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        tick();
        check("t1_vld_s3", {31'd0, bus.out_vld}, 32'd0);
        tick();
        check("t1_vld_s4", {31'd0, bus.out_vld}, 32'd1);
        check("t1_first", bus.out_data, 32'h105);
        tick();
        tick();
        tick();
        check("t1_lastflag", {31'd0, bus.out_last}, 32'd1);
        check("t1_lastdata", bus.out_data, 32'h108);
        tick();
        check("t1_done", {31'd0, bus.done}, 32'd1);
        tick();
        check("t1_done_off", {31'd0, bus.done}, 32'd0);
        check("t1_idle", {31'd0, bus.busy}, 32'd0);
        check("t1_drained", q.size(), 0);

        // Address wrap 127 -> 0
        exp_addr[0] = 7'd126;
        exp_addr[1] = 7'd127;
        exp_addr[2] = 7'd0;
        exp_addr[3] = 7'd1;
        cmd(7'd126, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", {25'd0, bus.m_rd_address}, {25'd0, exp_addr[i]});
            tick();
        end
        wait_done(20, "t2");
        check("t2_drained", q.size(), 0);

        // Backpressure: toggling ready, then a long stall
        hs = 0;
        cmd(7'd20, 8'd16, 1'b1);
        for (int i = 0; i < 20; i++) begin
            bus.out_rdy = (i % 2) == 0;
            tick();
        end
        bus.out_rdy = 1'b0;
        repeat (10) tick();
        check("t3_stall_vld", {31'd0, bus.out_vld}, 32'd1);
        bus.out_rdy = 1'b1;
        wait_done(60, "t3");
        check("t3_count", hs, 16);
        check("t3_drained", q.size(), 0);

        // Empty command: done next cycle, address held at last issued (35)
        cmd(7'd50, 8'd0, 1'b1);
        check("t4_done", {31'd0, bus.done}, 32'd1);
        check("t4_vld", {31'd0, bus.out_vld}, 32'd0);
        check("t4_addr", {25'd0, bus.m_rd_address}, 32'd35);
        tick();
        check("t4_idle", {31'd0, bus.busy}, 32'd0);

        // Oversized length clamps to 128 words
        hs = 0;
        cmd(7'd0, 8'd200, 1'b1);
        wait_done(400, "t5");
        check("t5_count", hs, 128);
        check("t5_drained", q.size(), 0);

        // Start while busy is ignored
        hs = 0;
        cmd(7'd10, 8'd8, 1'b1);
        tick();
        cmd(7'd90, 8'd3, 1'b0);
        wait_done(40, "t6");
        check("t6_count", hs, 8);
        check("t6_drained", q.size(), 0);

        // Reset during the third word of eight
        hs = 0;
        cmd(7'd40, 8'd8, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("t7_busy", {31'd0, bus.busy}, 32'd0);
        check("t7_vld", {31'd0, bus.out_vld}, 32'd0);
        check("t7_words_before", hs, 2);
        reset = 1'b0;
        q.delete();
        cmd(7'd100, 8'd3, 1'b1);
        wait_done(20, "t7");
        check("t7_drained", q.size(), 0);

`ifdef MEMORY_READER_ABORT_EN
        // Abort with words buffered under backpressure
        bus.out_rdy = 1'b0;
        cmd(7'd60, 8'd10, 1'b0);
        repeat (4) tick();
        check("t8_vld_pre", {31'd0, bus.out_vld}, 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t8_vld_post", {31'd0, bus.out_vld}, 32'd0);
        seen_done = 0;
        n = 0;
        while (bus.aborted !== 1'b1 && n < 6) begin
            if (bus.done === 1'b1) seen_done++;
            tick();
            n++;
        end
        check("t8_aborted", {31'd0, bus.aborted}, 32'd1);
        check("t8_no_done", seen_done, 0);
        tick();
        check("t8_idle", {31'd0, bus.busy}, 32'd0);
        check("t8_aborted_off", {31'd0, bus.aborted}, 32'd0);
        bus.out_rdy = 1'b1;
        cmd(7'd0, 8'd2, 1'b1);
        wait_done(20, "t8");
        check("t8_drained", q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
